alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
- Parametrised successor to the 4-bit reduced ALU. Supports a configurable WIDTH, a wider op set and a valid/ready handshake on both sides.
- All single-cycle ops give a registered result. MUL is an iterative shift-add unit: one multiplier bit per cycle, no combinational array multiplier.
- Sits between the issue stage and writeback in each superscalar lane. One instance per lane.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be ≥ 4 and a power of 2.
- SHW, $clog2(WIDTH), shift-amount width taken from b[SHW-1:0]. Derived; do not override.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and op are valid this cycle.
- in_ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A, two's complement.
- b  input  WIDTH  operand B, two's complement.
- op  input  4  operation select.
- out_valid  output  1  result/err are valid and held.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  registered result.
- err  output  1  op was an illegal encoding.
- busy  output  1  high while in state MUL.

Behaviour:
- Reset (async, rst=1): state=IDLE, out_valid=0, result=0, err=0, busy=0, internal accumulator/counter=0. in_ready=1 as soon as rst deasserts.
- Op encoding:
  - 0000 ADD a+b
  - 0001 SUB a−b
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 SLL a<<b[SHW-1:0]
  - 0110 SRL logical
  - 0111 SRA arithmetic
  - 1111 MUL, low WIDTH bits of a*b (identical for signed and unsigned)
  - Any other value: result=0, err=1, 1-cycle latency.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
- Handshake:
  - Transfer in = in_valid && in_ready. Transfer out = out_valid && out_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - a, b and op are captured only on an input transfer; input changes at other times are ignored.
- States:
  - IDLE: on input transfer of a non-MUL op, load result/err → DONE. On input transfer of MUL, load multiplicand=a, multiplier=b, acc=0, cnt=WIDTH-1 → MUL. No transfer: stay.
  - MUL: in_ready=0, busy=1. Each cycle: if multiplier[0], acc += multiplicand. Then multiplicand<<=1, multiplier>>=1. When cnt==0, write result=final acc, err=0 → DONE. Otherwise cnt−1.
  - DONE: out_valid=1; result/err held stable until out_ready.
    - out_ready=1 and no new input transfer → IDLE, out_valid=0.
    - out_ready=1 and a simultaneous input transfer → treat as a new IDLE acceptance in the same cycle. Non-MUL: stay DONE with new result (back-to-back, 1 op/cycle). MUL: → MUL.
- Latency, counted from the input-transfer edge:
  - Non-MUL: out_valid high in the next cycle.
  - MUL: out_valid high WIDTH+1 cycles later (e.g. 9 for WIDTH=8).
- Backpressure: if out_ready stays low, the result holds indefinitely and no new op is accepted.
- Reset mid-MUL or mid-DONE: the operation is discarded, outputs return to reset values immediately, and no stale out_valid appears after rst falls.
- op, a and b are don't-care while in_valid=0.

Test Plan (WIDTH=8):
- Reset then ADD: a=0x7F, b=0x01, op=0000, in_valid for 1 cycle → next cycle out_valid=1, result=0x80, err=0. With out_ready=1 → out_valid drops the following cycle.
- SUB/shift back-to-back with out_ready=1 held:
  - SUB 0x05−0x07 → 0xFE.
  - SRA a=0x80, b=0x03 → 0xF0.
  - SRL a=0x80, b=0x03 → 0x10.
  - SLL a=0x01, b=0x0F → 0x80 (shift amount 7).
  - Required: in_ready held 1 and one result per cycle.
- MUL latency: a=0xFD (−3), b=0x05, op=1111 → busy=1 and in_ready=0 for 8 cycles; out_valid rises 9 cycles after acceptance with result=0xF1. Also a=0x10, b=0x10 → 0x00 (wrap).
- Backpressure: ADD 3+4 with out_ready=0 for 5 cycles and in_valid=1 carrying new ops → result stays 0x07, in_ready=0, nothing accepted. Drop of the held result only when out_ready=1.
- Illegal op 1000 with a=0x12, b=0x34 → next cycle err=1, result=0x00. The following legal op clears err.
- Async reset asserted mid-way through a MUL (4th MUL cycle, between clock edges) → busy, out_valid and result go to 0 without a clock edge. After release, in_ready=1 and no spurious out_valid.

Source files
------------

// File: rtl/alu_multicycle_if.sv
// Handshake bundle for alu_multicycle: issue-side valid/ready with operands,
// writeback-side valid/ready with result, error and busy status.
interface alu_multicycle_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             err;
  logic             busy;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, result, err, busy
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, result, err, busy
  );
endinterface

// File: rtl/alu_multicycle.sv
// Parametrised ALU with valid/ready handshakes: single-cycle logic/arith/shift ops
// and an iterative shift-add multiplier retiring one multiplier bit per cycle.
module alu_multicycle #(
  parameter int unsigned WIDTH = 8
) (
  input logic            clk,
  input logic            rst,
  alu_multicycle_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd = 4'b0000;
  localparam logic [3:0] OpSub = 4'b0001;
  localparam logic [3:0] OpAnd = 4'b0010;
  localparam logic [3:0] OpOr  = 4'b0011;
  localparam logic [3:0] OpXor = 4'b0100;
  localparam logic [3:0] OpSll = 4'b0101;
  localparam logic [3:0] OpSrl = 4'b0110;
  localparam logic [3:0] OpSra = 4'b0111;
  localparam logic [3:0] OpMul = 4'b1111;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] result_q;
  logic             err_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [SHW-1:0]   cnt_q;

  logic             in_xfer;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_err;
  logic [WIDTH-1:0] acc_sum;

  assign bus.in_ready  = (state_q == StIdle) || ((state_q == StDone) && bus.out_ready);
  assign in_xfer       = bus.in_valid && bus.in_ready;
  assign shamt         = bus.b[SHW-1:0];
  assign acc_sum       = acc_q + (mplier_q[0] ? mcand_q : '0);

  assign bus.out_valid = (state_q == StDone);
  assign bus.busy      = (state_q == StMul);
  assign bus.result    = result_q;
  assign bus.err       = err_q;

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (bus.op)
      OpAdd:   alu_res = bus.a + bus.b;
      OpSub:   alu_res = bus.a - bus.b;
      OpAnd:   alu_res = bus.a & bus.b;
      OpOr:    alu_res = bus.a | bus.b;
      OpXor:   alu_res = bus.a ^ bus.b;
      OpSll:   alu_res = bus.a << shamt;
      OpSrl:   alu_res = bus.a >> shamt;
      OpSra:   alu_res = $signed(bus.a) >>> shamt;
      OpMul:   alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      result_q <= '0;
      err_q    <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        StMul: begin
          acc_q    <= acc_sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (cnt_q == '0) begin
            result_q <= acc_sum;
            err_q    <= 1'b0;
            state_q  <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          // An accept in DONE (with out_ready) behaves exactly like one in IDLE.
          if (in_xfer) begin
            if (bus.op == OpMul) begin
              mcand_q  <= bus.a;
              mplier_q <= bus.b;
              acc_q    <= '0;
              cnt_q    <= SHW'(WIDTH - 1);
              state_q  <= StMul;
            end else begin
              result_q <= alu_res;
              err_q    <= alu_err;
              state_q  <= StDone;
            end
          end else if ((state_q == StDone) && bus.out_ready) begin
            state_q <= StIdle;
          end else if (state_q != StDone) begin
            state_q <= StIdle;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle (WIDTH=8): expectations are queued on each
// accepted input and compared when the DUT hands a result over.
module tb_alu_multicycle;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_multicycle_if #(.WIDTH(8)) bus ();

  alu_multicycle #(.WIDTH(8)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int pops     = 0;
  logic [8:0] sb_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: {err, result}.
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] op);
    logic [7:0]  r;
    logic [15:0] p;
    logic [2:0]  sh;
    sh = b[2:0];
    r  = 8'h00;
    case (op)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = a << sh;
      4'h6: r = a >> sh;
      4'h7: r = $signed(a) >>> sh;
      4'hF: begin p = a * b; r = p[7:0]; end
      default: return {1'b1, 8'h00};
    endcase
    return {1'b0, r};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [8:0] exp;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("out_unexpected", 32'(bus.out_valid), 32'd0);
      end else begin
        exp = sb_q.pop_front();
        check_eq("sb_result", 32'(bus.result), 32'(exp[7:0]));
        check_eq("sb_err", 32'(bus.err), 32'(exp[8]));
        pops++;
      end
    end
  end

  // Call away from a clock edge; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                      output int acc_cyc);
    int waited;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.op       = op;
    waited       = 0;
    acc_cyc      = -1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waited++;
      if (waited > 100) begin
        check_eq("send_timeout", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        return;
      end
    end
    acc_cyc = cyc;
    @(posedge clk);
    sb_q.push_back(model(a, b, op));
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    int c0, c1, c2, c3, p0, lat, busy_cnt, k;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op        = '0;
    bus.out_ready = 1'b0;

    #2;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_result", 32'(bus.result), 32'd0);
    check_eq("rst_err", 32'(bus.err), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    #20 rst = 1'b0;
    #1 check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // ADD with one-cycle latency, then the output drops once taken.
    bus.out_ready = 1'b1;
    send(8'h7F, 8'h01, 4'h0, c0);
    check_eq("add_valid", 32'(bus.out_valid), 32'd1);
    check_eq("add_result", 32'(bus.result), 32'h80);
    check_eq("add_err", 32'(bus.err), 32'd0);
    @(posedge clk); #1;
    check_eq("add_drop", 32'(bus.out_valid), 32'd0);

    // Back-to-back single-cycle ops.
    p0 = pops;
    send(8'h05, 8'h07, 4'h1, c0);
    send(8'h80, 8'h03, 4'h7, c1);
    send(8'h80, 8'h03, 4'h6, c2);
    send(8'h01, 8'h0F, 4'h5, c3);
    @(posedge clk); #1;
    check_eq("b2b_cycles", 32'(c3 - c0), 32'd3);
    check_eq("b2b_pops", 32'(pops - p0), 32'd4);

    // MUL latency and busy window.
    send(8'hFD, 8'h05, 4'hF, c0);
    lat      = 1;
    busy_cnt = 0;
    while (!bus.out_valid && lat < 50) begin
      if (bus.busy && !bus.in_ready) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    check_eq("mul_latency", 32'(lat), 32'd9);
    check_eq("mul_busy_cycles", 32'(busy_cnt), 32'd8);
    check_eq("mul_result", 32'(bus.result), 32'hF1);
    @(posedge clk); #1;
    send(8'h10, 8'h10, 4'hF, c0);
    k = 0;
    while (!bus.out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("mul2_done", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;

    // Backpressure: held result, no new acceptance.
    bus.out_ready = 1'b0;
    send(8'h03, 8'h04, 4'h0, c0);
    bus.in_valid = 1'b1;
    bus.a        = 8'h09;
    bus.b        = 8'h01;
    bus.op       = 4'h1;
    repeat (5) begin
      @(negedge clk);
      check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check_eq("bp_valid", 32'(bus.out_valid), 32'd1);
      check_eq("bp_result", 32'(bus.result), 32'h07);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_drained", 32'(bus.out_valid), 32'd0);
    check_eq("bp_sb_empty", 32'(sb_q.size()), 32'd0);

    // Illegal op, then a legal op clears err.
    send(8'h12, 8'h34, 4'h8, c0);
    check_eq("ill_err", 32'(bus.err), 32'd1);
    check_eq("ill_result", 32'(bus.result), 32'd0);
    send(8'h01, 8'h01, 4'h0, c0);
    check_eq("legal_err_clr", 32'(bus.err), 32'd0);
    @(posedge clk); #1;

    // Async reset during the 4th MUL cycle.
    send(8'h03, 8'h05, 4'hF, c0);
    repeat (3) @(posedge clk);
    #3;
    check_eq("pre_rst_busy", 32'(bus.busy), 32'd1);
    check_eq("pre_rst_result", 32'(bus.result), 32'h02);
    rst = 1'b1;
    #1;
    check_eq("arst_busy", 32'(bus.busy), 32'd0);
    check_eq("arst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("arst_result", 32'(bus.result), 32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    #1 check_eq("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (12) begin
      @(negedge clk);
      check_eq("post_rst_no_valid", 32'(bus.out_valid), 32'd0);
    end

    check_eq("final_sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
